// File: rtl/timer_pkg.sv
// Shared types and constants for the cp_timer memory-mapped countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;
  localparam int CTRL_PS_LSB   = 4;

  // Byte-lane merge of a CPU store into an existing register word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] result;
    result = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) result[8*b +: 8] = new_word[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/cp_timer_if.sv
// Data-port bus between the CPU M-stage (via the system bridge) and cp_timer.
interface cp_timer_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output sel, we, addr, byteen, wdata, input rdata, irq);
  modport slave  (input sel, we, addr, byteen, wdata, output rdata, irq);
endinterface

// File: rtl/timer_prescaler.sv
// Divides the count rate: tick is high once every p+1 cycles while not cleared.
module timer_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] p,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;

  // >= rather than == so a shrinking p mid-count does not stall for a full wrap.
  always_comb begin
    tick = (cnt_q >= p);
    if (clear || tick) cnt_d = {W{1'b0}};
    else               cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= {W{1'b0}};
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cp_timer.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with a registered irq.
// Optional prescaler in CTRL[4 +: PRESCALE_W] when TIMER_PRESCALE_EN is defined.
module cp_timer
  import timer_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  cp_timer_if.slave   bus
);

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;
  logic        irq_q;

  logic        wr_s, ctrl_wr_s, preset_wr_s;
  logic [31:0] ctrl_word_s, ctrl_new_s;
  logic        en_sw_s, tick_s;
  logic        fsm_en_clr_s, fsm_flag_set_s, fsm_flag_clr_s;

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] presc_q, presc_d;

  timer_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (state_q != ST_CNT),
    .p     (presc_q),
    .tick  (tick_s)
  );
`else
  assign tick_s = 1'b1;
`endif

  always_comb begin
    ctrl_word_s                         = 32'd0;
    ctrl_word_s[CTRL_EN_BIT]            = en_q;
    ctrl_word_s[CTRL_MODE_LSB +: 2]     = mode_q;
    ctrl_word_s[CTRL_IM_BIT]            = im_q;
`ifdef TIMER_PRESCALE_EN
    ctrl_word_s[CTRL_PS_LSB +: PRESCALE_W] = presc_q;
`endif
  end

  always_comb begin
    case (bus.addr)
      OFF_CTRL:   bus.rdata = ctrl_word_s;
      OFF_PRESET: bus.rdata = preset_q;
      OFF_COUNT:  bus.rdata = count_q;
      default:    bus.rdata = 32'd0;
    endcase
  end

  assign wr_s        = bus.sel & bus.we;
  assign ctrl_wr_s   = wr_s && (bus.addr == OFF_CTRL);
  assign preset_wr_s = wr_s && (bus.addr == OFF_PRESET);
  assign ctrl_new_s  = merge_bytes(ctrl_word_s, bus.wdata, bus.byteen);
  // The FSM looks at EN as it will be after this cycle's store.
  assign en_sw_s     = ctrl_wr_s ? ctrl_new_s[CTRL_EN_BIT] : en_q;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    fsm_en_clr_s   = 1'b0;
    fsm_flag_set_s = 1'b0;
    fsm_flag_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_sw_s) state_d = ST_LOAD;
        else         state_d = ST_IDLE;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_sw_s) begin
          state_d = ST_IDLE;
        end else if (!tick_s) begin
          state_d = ST_CNT;
        end else if (count_q != 32'd0) begin
          count_d = count_q - 32'd1;
        end else begin
          state_d        = ST_INT;
          fsm_flag_set_s = 1'b1;
        end
      end
      ST_INT: begin
        if (mode_q == MODE_RELOAD) begin
          state_d        = ST_LOAD;
          fsm_flag_clr_s = 1'b1;
        end else begin
          state_d      = ST_IDLE;
          fsm_en_clr_s = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Software stores to CTRL take priority over FSM updates of EN and irq_flag.
  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
`ifdef TIMER_PRESCALE_EN
    presc_d  = presc_q;
`endif
    if (ctrl_wr_s) begin
      en_d       = ctrl_new_s[CTRL_EN_BIT];
      mode_d     = ctrl_new_s[CTRL_MODE_LSB +: 2];
      im_d       = ctrl_new_s[CTRL_IM_BIT];
`ifdef TIMER_PRESCALE_EN
      presc_d    = ctrl_new_s[CTRL_PS_LSB +: PRESCALE_W];
`endif
      irq_flag_d = 1'b0;
    end else begin
      if (fsm_en_clr_s) en_d = 1'b0;
      else              en_d = en_q;
      if (fsm_flag_set_s)      irq_flag_d = 1'b1;
      else if (fsm_flag_clr_s) irq_flag_d = 1'b0;
      else                     irq_flag_d = irq_flag_q;
    end
    if (preset_wr_s) preset_d = merge_bytes(preset_q, bus.wdata, bus.byteen);
    else             preset_d = preset_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      mode_q     <= 2'd0;
      im_q       <= 1'b0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      presc_q    <= {PRESCALE_W{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      im_q       <= im_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_flag_q & im_q;
`ifdef TIMER_PRESCALE_EN
      presc_q    <= presc_d;
`endif
    end
  end

  assign bus.irq = irq_q;

endmodule

// File: tb/tb_cp_timer.sv
// Self-checking bench for cp_timer: directed scenarios plus randomized runs
// compared against a closed-form timing model of the timer.
module tb_cp_timer;
  import timer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cp_timer_if bus();

  cp_timer #(.PRESCALE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

`ifdef TIMER_PRESCALE_EN
  localparam int P_TB = 2;
`else
  localparam int P_TB = 0;
`endif
  localparam logic [31:0] P_FIELD = 32'(P_TB) << 4;

  // Closed-form model; s = cycles since the cycle in which CTRL.EN was written.
  function automatic int mdl_count(int s, int n, int p, bit rel);
    int l, ph;
    l  = (n + 1) * (p + 1);
    ph = rel ? (s % (l + 2)) : s;
    if (ph == 0 || ph > l) return 0;
    return n - (ph - 1) / (p + 1);
  endfunction

  function automatic bit mdl_irq(int s, int n, int p, bit rel, bit im);
    int l;
    l = (n + 1) * (p + 1);
    if (!im) return 1'b0;
    if (rel) return (s > 0) && (s % (l + 2) == 0);
    return s >= l + 2;
  endfunction

  function automatic bit mdl_en(int s, int n, int p, bit rel);
    if (rel) return 1'b1;
    return s <= (n + 1) * (p + 1) + 1;
  endfunction

  task automatic do_reset();
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.byteen = 4'd0; bus.wdata = 32'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d; bus.byteen = be;
    @(posedge clk);
    #1;
    bus.sel = 1'b0; bus.we = 1'b0; bus.byteen = 4'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.addr = a;
    #1 d = bus.rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      total++;
      if (d !== 32'd0) begin
        bad++; $display("FAIL reset_rd%0d got=%h want=%h", a, d, 32'd0);
      end
    end
    total++;
    if (bus.irq !== 1'b0) begin
      bad++; $display("FAIL reset_irq got=%b want=0", bus.irq);
    end
  endtask

  task automatic test_readonly();
    logic [31:0] d, want;
    do_reset();
    bus_write(OFF_COUNT, 32'h0000_1234, 4'b1111);
    bus_write(2'd3, 32'hFFFF_FFFF, 4'b1111);
    bus_read(OFF_COUNT, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL count_ro got=%h want=%h", d, 32'd0); end
    bus_read(2'd3, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL rsvd_rd got=%h want=%h", d, 32'd0); end
    bus_read(OFF_PRESET, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL preset_untouched got=%h want=%h", d, 32'd0); end
    bus_write(OFF_CTRL, 32'hFFFF_FFF0, 4'b1111);
`ifdef TIMER_PRESCALE_EN
    want = 32'h0000_0FF0;
`else
    want = 32'h0000_0000;
`endif
    bus_read(OFF_CTRL, d);
    total++;
    if (d !== want) begin bad++; $display("FAIL ctrl_psbits got=%h want=%h", d, want); end
  endtask

  task automatic test_oneshot();
    logic [31:0] c, k;
    int l;
    do_reset();
    l = 4 * (P_TB + 1);
    bus_write(OFF_PRESET, 32'd3, 4'b1111);
    bus_write(OFF_CTRL, 32'h9 | P_FIELD, 4'b1111);
    for (int s = 0; s <= l + 6; s++) begin
      bus_read(OFF_COUNT, c);
      bus_read(OFF_CTRL, k);
      total++;
      if (c !== 32'(mdl_count(s, 3, P_TB, 1'b0)) || bus.irq !== mdl_irq(s, 3, P_TB, 1'b0, 1'b1)
          || k[0] !== mdl_en(s, 3, P_TB, 1'b0)) begin
        bad++;
        $display("FAIL oneshot s=%0d got cnt=%0d irq=%b en=%b want cnt=%0d irq=%b en=%b", s, c, bus.irq,
                 k[0], mdl_count(s, 3, P_TB, 1'b0), mdl_irq(s, 3, P_TB, 1'b0, 1'b1), mdl_en(s, 3, P_TB, 1'b0));
      end
      @(posedge clk); #1;
    end
    bus_write(OFF_CTRL, 32'd0, 4'b1111);
    @(posedge clk); #1;
    total++;
    if (bus.irq !== 1'b0) begin bad++; $display("FAIL oneshot_irq_clear got=%b want=0", bus.irq); end
  endtask

  task automatic test_reload();
    logic [31:0] c;
    int per, pulses;
    do_reset();
    per    = 3 * (P_TB + 1) + 2;
    pulses = 0;
    bus_write(OFF_PRESET, 32'd2, 4'b1111);
    bus_write(OFF_CTRL, 32'hB | P_FIELD, 4'b1111);
    for (int s = 0; s <= 4 * per; s++) begin
      bus_read(OFF_COUNT, c);
      if (bus.irq === 1'b1) pulses++;
      total++;
      if (c !== 32'(mdl_count(s, 2, P_TB, 1'b1)) || bus.irq !== mdl_irq(s, 2, P_TB, 1'b1, 1'b1)) begin
        bad++;
        $display("FAIL reload s=%0d got cnt=%0d irq=%b want cnt=%0d irq=%b", s, c, bus.irq,
                 mdl_count(s, 2, P_TB, 1'b1), mdl_irq(s, 2, P_TB, 1'b1, 1'b1));
      end
      @(posedge clk); #1;
    end
    total++;
    if (pulses != 4) begin bad++; $display("FAIL reload_pulses got=%0d want=4", pulses); end
  endtask

  task automatic test_byteen();
    logic [31:0] d;
    do_reset();
    bus_write(OFF_PRESET, 32'hAABB_CCDD, 4'b1111);
    bus_write(OFF_PRESET, 32'h1122_3344, 4'b0101);
    bus_read(OFF_PRESET, d);
    total++;
    if (d !== 32'hAA22_CC44) begin bad++; $display("FAIL byteen got=%h want=%h", d, 32'hAA22_CC44); end
  endtask

  task automatic test_midreset();
    logic [31:0] c, k;
    int waited;
    do_reset();
    bus_write(OFF_PRESET, 32'd8, 4'b1111);
    bus_write(OFF_CTRL, 32'h9 | P_FIELD, 4'b1111);
    waited = 0;
    bus_read(OFF_COUNT, c);
    while (c !== 32'd5 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
      bus_read(OFF_COUNT, c);
    end
    total++;
    if (waited >= 200) begin bad++; $display("FAIL midreset_wait got=%0d want=5", c); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus_read(OFF_COUNT, c);
    bus_read(OFF_CTRL, k);
    total++;
    if (c !== 32'd0 || k !== 32'd0 || bus.irq !== 1'b0) begin
      bad++; $display("FAIL midreset_state got cnt=%h ctrl=%h irq=%b want 0 0 0", c, k, bus.irq);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus_read(OFF_COUNT, c);
      total++;
      if (bus.irq !== 1'b0 || c !== 32'd0) begin
        bad++; $display("FAIL midreset_quiet i=%0d got irq=%b cnt=%h want 0 0", i, bus.irq, c);
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] k;
    do_reset();
    bus_write(OFF_PRESET, 32'd1, 4'b1111);
    bus_write(OFF_CTRL, {30'd0, MODE_ONESHOT} << 1 | 32'h9 | P_FIELD, 4'b1111);
    repeat (2 * (P_TB + 1) + 1) begin @(posedge clk); #1; end
    bus_write(OFF_CTRL, 32'h9 | P_FIELD, 4'b1111);
    bus_read(OFF_CTRL, k);
    total++;
    if (k[0] !== 1'b1) begin bad++; $display("FAIL collision_en got=%b want=1", k[0]); end
  endtask

  task automatic test_random();
    logic [31:0] c, k;
    int n, mode, im, per;
    bit rel;
    for (int t = 0; t < 8; t++) begin
      do_reset();
      n    = int'($urandom_range(0, 6));
      mode = int'($urandom_range(0, 3));
      im   = int'($urandom_range(0, 1));
      rel  = (mode == 1);
      per  = (n + 1) * (P_TB + 1) + 2;
      bus_write(OFF_PRESET, 32'(n), 4'b1111);
      bus_write(OFF_CTRL, 32'h1 | (32'(mode) << 1) | (32'(im) << 3) | P_FIELD, 4'b1111);
      for (int s = 0; s <= 2 * per + 3; s++) begin
        bus_read(OFF_COUNT, c);
        bus_read(OFF_CTRL, k);
        total++;
        if (c !== 32'(mdl_count(s, n, P_TB, rel)) || bus.irq !== mdl_irq(s, n, P_TB, rel, im[0])
            || k[0] !== mdl_en(s, n, P_TB, rel)) begin
          bad++;
          $display("FAIL random t=%0d n=%0d mode=%0d im=%0d s=%0d got cnt=%0d irq=%b en=%b want cnt=%0d irq=%b en=%b",
                   t, n, mode, im, s, c, bus.irq, k[0], mdl_count(s, n, P_TB, rel),
                   mdl_irq(s, n, P_TB, rel, im[0]), mdl_en(s, n, P_TB, rel));
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_prescale();
`ifdef TIMER_PRESCALE_EN
    int first;
    do_reset();
    first = -1;
    bus_write(OFF_PRESET, 32'd2, 4'b1111);
    bus_write(OFF_CTRL, 32'h9 | P_FIELD, 4'b1111);
    for (int s = 0; s < 40; s++) begin
      if (bus.irq === 1'b1 && first < 0) first = s;
      @(posedge clk); #1;
    end
    // Without prescaling irq is seen at s = PRESET+3; P=2 adds 6 cycles.
    total++;
    if (first != 2 + 3 + 6) begin bad++; $display("FAIL prescale_irq_at got=%0d want=%0d", first, 11); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_readonly();
    test_oneshot();
    test_reload();
    test_byteen();
    test_midreset();
    test_collision();
    test_random();
    test_prescale();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
